// File: rtl/ps2_seq_pkg.sv
// rtl/ps2_seq_pkg.sv - shared state encoding and PS/2 prefix byte constants
package ps2_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE_E0,
        ST_PRE_F0,
        ST_PRE_E0F0,
        ST_EMIT
    } seq_state_t;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERRF = 8'hFF;

endpackage

// File: rtl/ps2_prefix_timer.sv
// rtl/ps2_prefix_timer.sv - loadable down-counter bounding the gap after a prefix byte
module ps2_prefix_timer #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic clrn,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(TIMEOUT);
        end else if (run && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/ps2_scan_sequencer.sv
// rtl/ps2_scan_sequencer.sv - pops PS/2 scan bytes, folds E0/F0 prefixes into make/break events
module ps2_scan_sequencer
    import ps2_seq_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             rx_ready,
    input  logic [7:0]       rx_data,
    output logic             rx_next_n,
    input  logic             rx_overflow,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic             key_held,
    output logic [7:0]       held_code,
    output logic [CNT_W-1:0] press_count,
    output logic             err,
    input  logic             err_clr
);

    seq_state_t state;
    logic       popped_q;
    logic       held_ext;
    logic       in_pre;
    logic       pop;
    logic       seq_ext;
    logic       seq_brk;
    logic       held_match;
    logic       decode_err;
    logic       expired;
    logic       timeout;
    logic       err_set;

    assign in_pre  = (state == ST_PRE_E0) || (state == ST_PRE_F0) || (state == ST_PRE_E0F0);
    // popped_q resets high so the first cycle after reset never pops
    assign pop       = (state != ST_EMIT) && rx_ready && !popped_q;
    assign rx_next_n = ~pop;

    assign seq_ext    = (state == ST_PRE_E0) || (state == ST_PRE_E0F0);
    assign seq_brk    = (state == ST_PRE_F0) || (state == ST_PRE_E0F0);
    assign held_match = key_held && (held_ext == seq_ext) && (held_code == rx_data);

    always_comb begin
        decode_err = 1'b0;
        if (pop) begin
            if (rx_data == PS2_ERR0 || rx_data == PS2_ERRF) begin
                decode_err = 1'b1;
            end else if (rx_data == PS2_EXT) begin
                decode_err = in_pre;
            end else if (rx_data == PS2_BRK) begin
                decode_err = (state == ST_PRE_F0) || (state == ST_PRE_E0F0);
            end
        end
    end

    ps2_prefix_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .clrn    (clrn),
        .load    (pop),
        .run     (in_pre && !pop),
        .expired (expired)
    );

    assign timeout = in_pre && !pop && expired;
    assign err_set = decode_err || timeout || rx_overflow;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= ST_IDLE;
            popped_q    <= 1'b1;
            evt_valid   <= 1'b0;
            evt_code    <= 8'h00;
            evt_ext     <= 1'b0;
            evt_break   <= 1'b0;
            key_held    <= 1'b0;
            held_code   <= 8'h00;
            held_ext    <= 1'b0;
            press_count <= '0;
            err         <= 1'b0;
        end else begin
            popped_q <= pop;
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            case (state)
                ST_EMIT: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    if (pop) begin
                        if (rx_data == PS2_ERR0 || rx_data == PS2_ERRF) begin
                            state <= ST_IDLE;
                        end else if (rx_data == PS2_EXT) begin
                            state <= (state == ST_IDLE) ? ST_PRE_E0 : ST_IDLE;
                        end else if (rx_data == PS2_BRK) begin
                            if (state == ST_IDLE)
                                state <= ST_PRE_F0;
                            else if (state == ST_PRE_E0)
                                state <= ST_PRE_E0F0;
                            else
                                state <= ST_IDLE;
                        end else if (!seq_brk && held_match) begin
                            // typematic repeat of the key already down
                            state <= ST_IDLE;
                        end else begin
                            if (!seq_brk) begin
                                held_code <= rx_data;
                                held_ext  <= seq_ext;
                                key_held  <= 1'b1;
                                if (press_count != '1)
                                    press_count <= press_count + CNT_W'(1);
                            end else if (held_match) begin
                                key_held <= 1'b0;
                            end
                            evt_code  <= rx_data;
                            evt_ext   <= seq_ext;
                            evt_break <= seq_brk;
                            evt_valid <= 1'b1;
                            state     <= ST_EMIT;
                        end
                    end else if (timeout) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// tb/tb_ps2_scan_sequencer.sv - scoreboard bench for ps2_scan_sequencer
module tb_ps2_scan_sequencer;

    localparam int TO = 20;

    logic       clk;
    logic       clrn;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_next_n;
    logic       rx_overflow;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       key_held;
    logic [7:0] held_code;
    logic [7:0] press_count;
    logic       err;
    logic       err_clr;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       held;
        logic [7:0] cnt;
    } ev_t;

    ev_t        sb[$];
    logic [7:0] rx_q[$];
    ev_t        mon_e;
    logic [7:0] exp_cnt;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         pops = 0;
    int         last_pop = -1;
    bit         model_pop;
    bit         prev_v;

    ps2_scan_sequencer #(.CNT_W(8), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_next_n   (rx_next_n),
        .rx_overflow (rx_overflow),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_code    (evt_code),
        .evt_ext     (evt_ext),
        .evt_break   (evt_break),
        .key_held    (key_held),
        .held_code   (held_code),
        .press_count (press_count),
        .err         (err),
        .err_clr     (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_q.push_back(b);
    endtask

    task automatic add_evt(input logic [7:0] c, input logic x, input logic b, input logic h);
        ev_t e;
        if (!b && exp_cnt != 8'hFF) exp_cnt++;
        e.code = c;
        e.ext  = x;
        e.brk  = b;
        e.held = h;
        e.cnt  = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int n = 0;
        while ((rx_q.size() != 0 || sb.size() != 0 || evt_valid) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < max_cyc), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int n = 0;
        while (!evt_valid && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(evt_valid), 32'd1);
    endtask

    // receiver FIFO model: head byte presented while non-empty, removed on pop strobe
    initial begin
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        forever begin
            @(posedge clk);
            model_pop = !rx_next_n;
            if (model_pop) begin
                if (last_pop >= 0) check("pop_spacing", 32'(cyc - last_pop >= 2), 32'd1);
                last_pop = cyc;
                pops++;
            end
            cyc++;
            #1;
            if (model_pop && rx_q.size() > 0) void'(rx_q.pop_front());
            rx_ready = (rx_q.size() > 0);
            rx_data  = rx_ready ? rx_q[0] : 8'h00;
        end
    end

    initial begin
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (evt_valid && !prev_v && last_pop >= 0)
                check("evt_latency", 32'(cyc), 32'(last_pop + 1));
            if (evt_valid && evt_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_evt_code", 32'(evt_code), 32'h100);
                end else begin
                    mon_e = sb.pop_front();
                    check("evt_code", 32'(evt_code), 32'(mon_e.code));
                    check("evt_ext", 32'(evt_ext), 32'(mon_e.ext));
                    check("evt_break", 32'(evt_break), 32'(mon_e.brk));
                    check("evt_key_held", 32'(key_held), 32'(mon_e.held));
                    check("evt_press_count", 32'(press_count), 32'(mon_e.cnt));
                end
            end
            prev_v = evt_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int n;
        int n0;
        clrn        = 1'b0;
        evt_ready   = 1'b1;
        rx_overflow = 1'b0;
        err_clr     = 1'b0;
        exp_cnt     = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_next_n", 32'(rx_next_n), 32'd1);
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_evt_code", 32'(evt_code), 32'd0);
        check("rst_key_held", 32'(key_held), 32'd0);
        check("rst_held_code", 32'(held_code), 32'd0);
        check("rst_press_count", 32'(press_count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        step(1);
        clrn = 1'b1;

        // plain make then break
        step(1);
        send(8'h1C); send(8'hF0); send(8'h1C);
        add_evt(8'h1C, 1'b0, 1'b0, 1'b1);
        add_evt(8'h1C, 1'b0, 1'b1, 1'b0);
        drain("drain_plain", 100);
        check("cnt_plain", 32'(press_count), 32'(exp_cnt));

        // extended make and break
        step(1);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        add_evt(8'h75, 1'b1, 1'b0, 1'b1);
        add_evt(8'h75, 1'b1, 1'b1, 1'b0);
        drain("drain_ext", 100);
        check("held_after_ext", 32'(key_held), 32'd0);

        // typematic repeats are swallowed
        step(1);
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        add_evt(8'h1C, 1'b0, 1'b0, 1'b1);
        add_evt(8'h1C, 1'b0, 1'b1, 1'b0);
        drain("drain_typematic", 100);
        check("cnt_typematic", 32'(press_count), 32'(exp_cnt));

        // consumer back-pressure holds the event and blocks pops
        step(1);
        evt_ready = 1'b0;
        send(8'h1C); send(8'hF0); send(8'h1C);
        add_evt(8'h1C, 1'b0, 1'b0, 1'b1);
        add_evt(8'h1C, 1'b0, 1'b1, 1'b0);
        wait_valid("stall_valid", 50);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid_hold", 32'(evt_valid), 32'd1);
            check("stall_code", 32'(evt_code), 32'h1C);
            check("stall_no_pop", 32'(rx_next_n), 32'd1);
        end
        check("stall_rx_ready", 32'(rx_ready), 32'd1);
        step(1);
        evt_ready = 1'b1;
        drain("drain_stall", 100);

        // prefix timeout
        step(1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        @(negedge clk);
        check("err_cleared", 32'(err), 32'd0);
        step(1);
        p = pops;
        send(8'hF0);
        n = 0;
        while (pops == p && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("timeout_pop_seen", 32'(pops > p), 32'd1);
        n0 = last_pop;
        while (cyc < n0 + TO - 1) @(negedge clk);
        check("err_before_timeout", 32'(err), 32'd0);
        while (cyc < n0 + TO + 3) @(negedge clk);
        check("err_after_timeout", 32'(err), 32'd1);
        check("no_evt_on_timeout", 32'(evt_valid), 32'd0);
        step(1);
        send(8'h1C);
        add_evt(8'h1C, 1'b0, 1'b0, 1'b1);
        drain("drain_after_timeout", 100);
        step(1);
        send(8'hF0); send(8'h1C);
        add_evt(8'h1C, 1'b0, 1'b1, 1'b0);
        drain("drain_release", 100);

        // error flag set/clear priority and decode errors
        step(1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        @(negedge clk);
        check("err_clr_alone", 32'(err), 32'd0);
        step(1);
        err_clr     = 1'b1;
        rx_overflow = 1'b1;
        step(1);
        err_clr     = 1'b0;
        rx_overflow = 1'b0;
        @(negedge clk);
        check("err_set_wins", 32'(err), 32'd1);
        step(1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        send(8'h00);
        drain("drain_byte00", 100);
        check("err_byte00", 32'(err), 32'd1);
        step(1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        send(8'hE0); send(8'hE0);
        drain("drain_e0e0", 100);
        check("err_e0e0", 32'(err), 32'd1);
        check("cnt_after_errors", 32'(press_count), 32'(exp_cnt));

        // press counter saturation
        step(1);
        for (int i = 0; i < 252; i++) begin
            send((i % 2 == 0) ? 8'h10 : 8'h11);
            add_evt((i % 2 == 0) ? 8'h10 : 8'h11, 1'b0, 1'b0, 1'b1);
        end
        drain("drain_saturate", 2000);
        check("cnt_saturated", 32'(press_count), 32'hFF);
        check("held_code_last", 32'(held_code), 32'h11);

        // reset while an event is pending
        step(1);
        rx_overflow = 1'b1;
        step(1);
        rx_overflow = 1'b0;
        evt_ready   = 1'b0;
        send(8'h2A); send(8'h3B);
        wait_valid("rst_pending_valid", 50);
        step(1);
        clrn = 1'b0;
        #1;
        check("mid_rst_evt_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_evt_code", 32'(evt_code), 32'd0);
        check("mid_rst_evt_ext", 32'(evt_ext), 32'd0);
        check("mid_rst_evt_break", 32'(evt_break), 32'd0);
        check("mid_rst_key_held", 32'(key_held), 32'd0);
        check("mid_rst_held_code", 32'(held_code), 32'd0);
        check("mid_rst_press_count", 32'(press_count), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        exp_cnt = 8'h00;
        step(2);
        check("rst_hold_no_pop", 32'(rx_next_n), 32'd1);
        clrn = 1'b1;
        p = pops;
        @(negedge clk);
        check("first_cycle_no_pop", 32'(rx_next_n), 32'd1);
        @(negedge clk);
        check("first_edge_no_pop", 32'(pops), 32'(p));
        add_evt(8'h3B, 1'b0, 1'b0, 1'b1);
        step(1);
        evt_ready = 1'b1;
        drain("drain_after_reset", 100);
        check("cnt_after_reset", 32'(press_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
